// File: rtl/atm_cell_rr_sched.sv
// Round-robin cell scheduler: drains one CELL_LEN-byte cell at a time from N per-port FIFOs.
// Optional stall-abort feature is enabled by defining STALL_TIMEOUT_EN.
module atm_cell_rr_sched #(
    parameter int N_PORTS   = 4,
    parameter int DW        = 8,
    parameter int CELL_LEN  = 53,
    parameter int STALL_MAX = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_PORTS-1:0]         fifo_empty,
    input  logic [N_PORTS*DW-1:0]      fifo_dout,
    output logic [N_PORTS-1:0]         fifo_read,
    input  logic                       out_ready,
    output logic [DW-1:0]              out_data,
    output logic                       out_valid,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic [$clog2(N_PORTS)-1:0] out_port,
    output logic                       busy,
    output logic                       cell_abort
);
    localparam int PW = $clog2(N_PORTS);
    localparam int CW = $clog2(CELL_LEN);

    typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t          state_r;
    logic [PW-1:0]   grant_r;
    logic [PW-1:0]   last_grant_r;
    logic [CW-1:0]   cnt_r;
    logic [PW-1:0]   pick_s;
    logic            any_s;
    logic            rd_s;
    logic            last_s;
    logic            abort_s;
    logic            s1_valid_r;
    logic            s1_sop_r;
    logic            s1_eop_r;
    logic [PW-1:0]   s1_port_r;

    // Next port to serve: first non-empty FIFO after the last granted one, wrapping.
    always_comb begin
        pick_s = last_grant_r;
        any_s  = 1'b0;
        for (int i = 1; i <= N_PORTS; i++) begin
            int  idx;
            logic hit;
            idx    = (int'(last_grant_r) + i) % N_PORTS;
            hit    = !any_s && !fifo_empty[idx];
            pick_s = hit ? PW'(idx) : pick_s;
            any_s  = any_s | hit;
        end
    end

    // Read strobe for the granted FIFO only.
    always_comb begin
        fifo_read = '0;
        rd_s      = (state_r == XFER) && out_ready && !fifo_empty[grant_r];
        last_s    = rd_s && (cnt_r == CW'(CELL_LEN - 1));
        fifo_read[grant_r] = rd_s;
    end

    assign busy = (state_r == XFER);

`ifdef STALL_TIMEOUT_EN
    localparam int SW = $clog2(STALL_MAX + 1);
    logic [SW-1:0] stall_r;

    assign abort_s = (state_r == XFER) && fifo_empty[grant_r] && (stall_r == SW'(STALL_MAX - 1));

    // Consecutive starved XFER cycles; any read restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_r    <= '0;
            cell_abort <= 1'b0;
        end else begin
            cell_abort <= abort_s;
            if (state_r != XFER || rd_s || abort_s) begin
                stall_r <= '0;
            end else if (fifo_empty[grant_r]) begin
                stall_r <= stall_r + SW'(1);
            end else begin
                stall_r <= stall_r;
            end
        end
    end
`else
    assign abort_s    = 1'b0;
    assign cell_abort = 1'b0;
`endif

    // Grant FSM and per-cell byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            grant_r      <= '0;
            last_grant_r <= PW'(N_PORTS - 1);
            cnt_r        <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        grant_r <= pick_s;
                        state_r <= XFER;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                XFER: begin
                    if (last_s || abort_s) begin
                        state_r      <= IDLE;
                        cnt_r        <= '0;
                        last_grant_r <= grant_r;
                    end else if (rd_s) begin
                        cnt_r <= cnt_r + CW'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Two-stage output pipeline; FIFO data is valid one cycle after its strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_sop_r   <= 1'b0;
            s1_eop_r   <= 1'b0;
            s1_port_r  <= '0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_data   <= '0;
            out_port   <= '0;
        end else begin
            s1_valid_r <= rd_s;
            s1_sop_r   <= (cnt_r == '0);
            s1_eop_r   <= (cnt_r == CW'(CELL_LEN - 1));
            s1_port_r  <= grant_r;
            out_valid  <= s1_valid_r;
            out_sop    <= s1_valid_r & s1_sop_r;
            out_eop    <= s1_valid_r & s1_eop_r;
            if (s1_valid_r) begin
                out_data <= fifo_dout[int'(s1_port_r) * DW +: DW];
                out_port <= s1_port_r;
            end else begin
                out_data <= out_data;
                out_port <= out_port;
            end
        end
    end
endmodule

// File: tb/tb_atm_cell_rr_sched.sv
// Directed bench for atm_cell_rr_sched: behavioural FIFOs, byte scoreboard and per-test ordering checks.
module tb_atm_cell_rr_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  fifo_empty;
    logic [31:0] fifo_dout;
    logic [3:0]  fifo_read;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_valid, out_sop, out_eop;
    logic [1:0]  out_port;
    logic        busy, cell_abort;

    logic [7:0]  mem [4][1024];
    logic [7:0]  dout_r [4];
    int          rd_ptr [4];
    int          wr_ptr [4];
    int          mon_ptr [4];
    logic [3:0]  starve;
    logic [3:0]  allow;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    int          bcnt = 0;
    int          cur_port = 0;
    int          last_eop = 0;
    bit          have_eop = 0;
    bit          gap_chk = 0;
    int          abort_cnt = 0;
    int          abort_cyc = 0;
    int          starve_cyc = 0;
    int          cells_done [$];
    int          exp_q [$];

    atm_cell_rr_sched #(.N_PORTS(4), .DW(8), .CELL_LEN(53), .STALL_MAX(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_read  (fifo_read),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_port   (out_port),
        .busy       (busy),
        .cell_abort (cell_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: pointer compare for empty, registered read data.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fifo_empty[i]        = (rd_ptr[i] == wr_ptr[i]) || starve[i];
            fifo_dout[i*8 +: 8]  = dout_r[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (fifo_read[i]) begin
                dout_r[i] <= mem[i][rd_ptr[i] & 1023];
                rd_ptr[i] <= rd_ptr[i] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: byte order per port, cell framing and strobe legality.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("read_onehot", 32'($onehot0(fifo_read)), 32'd1);
            chk("read_when_empty", 32'(fifo_read & fifo_empty), 32'd0);
            chk("foreign_read", 32'(fifo_read & ~allow), 32'd0);
            if (cell_abort) begin
                abort_cnt++;
                abort_cyc = cyc;
                bcnt = 0;
            end
            if (out_valid) begin
                chk("data", 32'(out_data), 32'(mem[out_port][mon_ptr[out_port] & 1023]));
                chk("sop", 32'(out_sop), 32'(bcnt == 0));
                chk("eop", 32'(out_eop), 32'(bcnt == 52));
                if (bcnt == 0) begin
                    cur_port = int'(out_port);
                    if (gap_chk && have_eop) chk("cell_gap", 32'(cyc - last_eop), 32'd2);
                end else begin
                    chk("port_steady", 32'(out_port), 32'(cur_port));
                end
                mon_ptr[out_port] = mon_ptr[out_port] + 1;
                if (bcnt == 52) begin
                    bcnt = 0;
                    cells_done.push_back(int'(out_port));
                    last_eop = cyc;
                    have_eop = 1;
                end else begin
                    bcnt++;
                end
            end
        end
    end

    task automatic load(input int p, input int n);
        wr_ptr[p] = wr_ptr[p] + n;
    endtask

    task automatic wait_reads(input int p, input int target, input int budget);
        int k = 0;
        while (rd_ptr[p] != target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("read_timeout", 32'(rd_ptr[p]), 32'(target));
    endtask

    task automatic wait_cells(input int n, input int budget);
        int k = 0;
        while (cells_done.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("cell_timeout", 32'(cells_done.size()), 32'(n));
    endtask

    task automatic expect_order(input string tag);
        chk(tag, 32'(cells_done.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk(tag, (i < cells_done.size()) ? 32'(cells_done[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
        cells_done.delete();
    endtask

    task automatic chk_zero_outputs();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sop", 32'(out_sop), 32'd0);
        chk("rst_out_eop", 32'(out_eop), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_port", 32'(out_port), 32'd0);
        chk("rst_fifo_read", 32'(fifo_read), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cell_abort", 32'(cell_abort), 32'd0);
    endtask

    initial begin
        int b, tv;
        rst_n = 1'b0;
        out_ready = 1'b1;
        starve = 4'b0000;
        allow = 4'b1111;
        for (int p = 0; p < 4; p++) begin
            rd_ptr[p] = 0; wr_ptr[p] = 0; mon_ptr[p] = 0; dout_r[p] = 8'h00;
            for (int k = 0; k < 1024; k++) mem[p][k] = 8'($urandom);
        end
        repeat (3) @(negedge clk);
        chk_zero_outputs();

        // Test 1: all ports hold two cells, strict rotation starting at port 0.
        gap_chk = 1;
        rst_n = 1'b1;
        for (int p = 0; p < 4; p++) load(p, 106);
        @(negedge clk);
        chk("t1_first_read", 32'(fifo_read), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_latency_v0", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t1_latency_v1", 32'(out_valid), 32'd1);
        chk("t1_first_sop", 32'(out_sop), 32'd1);
        wait_cells(8, 1000);
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
        expect_order("t1_order");
        repeat (4) @(negedge clk);
        chk("t1_idle", 32'(busy), 32'd0);

        // Test 2: only port 2 busy, three back-to-back cells.
        have_eop = 0;
        allow = 4'b0100;
        load(2, 159);
        wait_cells(3, 600);
        exp_q = '{2, 2, 2};
        expect_order("t2_order");
        allow = 4'b1111;
        gap_chk = 0;
        repeat (4) @(negedge clk);

        // Test 3: port 1 starves after byte 20; grant must be held.
        b = rd_ptr[1];
        load(1, 53);
        wait_reads(1, b + 20, 200);
        starve[1] = 1'b1;
        load(3, 53);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t3_starve_no_read", 32'(fifo_read), 32'd0);
            chk("t3_busy_held", 32'(busy), 32'd1);
            @(negedge clk);
        end
        starve[1] = 1'b0;
        wait_cells(2, 400);
        exp_q = '{1, 3};
        expect_order("t3_order");
        repeat (4) @(negedge clk);

        // Test 4: out_ready low at byte 30 for five cycles.
        b = rd_ptr[0];
        load(0, 53);
        wait_reads(0, b + 30, 200);
        out_ready = 1'b0;
        tv = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_no_read", 32'(fifo_read), 32'd0);
            tv += int'(out_valid);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("t4_trailing_valid", 32'(tv), 32'd2);
        wait_cells(1, 200);
        exp_q = '{0};
        expect_order("t4_order");
        repeat (4) @(negedge clk);

        // Test 5: asynchronous reset in the middle of a port 1 cell.
        b = rd_ptr[1];
        load(0, 53);
        load(1, 53);
        wait_reads(1, b + 30, 200);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs();
        @(negedge clk);
        for (int p = 0; p < 4; p++) mon_ptr[p] = rd_ptr[p];
        bcnt = 0;
        cells_done.delete();
        load(1, 30);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_first_grant", 32'(fifo_read), 32'd1);
        wait_cells(2, 400);
        exp_q = '{0, 1};
        expect_order("t5_order");
        repeat (4) @(negedge clk);

        // Test 6: port 0 starves at byte 10 while port 3 waits.
        b = rd_ptr[0];
        abort_cnt = 0;
        load(0, 53);
        wait_reads(0, b + 1, 50);
        load(3, 53);
        wait_reads(0, b + 10, 50);
        starve[0] = 1'b1;
        starve_cyc = cyc;
`ifdef STALL_TIMEOUT_EN
        tv = 0;
        while (abort_cnt == 0 && tv < 200) begin
            @(negedge clk);
            tv++;
        end
        chk("t6_abort_seen", 32'(abort_cnt), 32'd1);
        chk("t6_abort_delay", 32'(abort_cyc - starve_cyc), 32'd64);
        wait_cells(1, 200);
        exp_q = '{3};
        expect_order("t6_next_port");
        starve[0] = 1'b0;
        load(0, 10);
        wait_cells(1, 200);
        exp_q = '{0};
        expect_order("t6_refill");
`else
        repeat (100) @(negedge clk);
        chk("t6_busy_held", 32'(busy), 32'd1);
        chk("t6_no_read", 32'(fifo_read), 32'd0);
        chk("t6_no_abort", 32'(abort_cnt), 32'd0);
        chk("t6_no_cell", 32'(cells_done.size()), 32'd0);
        starve[0] = 1'b0;
        wait_cells(2, 400);
        exp_q = '{0, 3};
        expect_order("t6_order");
`endif
        repeat (4) @(negedge clk);
        for (int p = 0; p < 4; p++) chk("drained", 32'(rd_ptr[p]), 32'(wr_ptr[p]));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
